seq_divider_4bit: RTL and testbench

//  Iterative restoring unsigned divider. It is the inverse-operation companion to
//  the 4-bit array multiplier: given a = prod / b, it returns quotient and remainder.
//  It resolves one quotient bit per clock and uses a start/busy/done handshake.
//  Its results can be cross-checked against the multiplier (q*b + r == a).

---
 rtl/seq_divider_4bit_if.sv | 36 +++
 rtl/seq_divider_4bit.sv | 112 +++++++++++
 tb/tb_seq_divider_4bit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/seq_divider_4bit_if.sv
// Handshake and data bundle for the sequential divider.
// master drives requests, slave returns results.
interface seq_divider_4bit_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/seq_divider_4bit.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// start/busy/done handshake; results held until the next result.
module seq_divider_4bit #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_divider_4bit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [2*WIDTH-1:0] sh;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   r_nx;
    logic [WIDTH-1:0]   q_nx;

    // R never exceeds the dividend prefix seen so far, so the
    // shifted R always fits in WIDTH bits.
    always_comb begin
        sh   = {r_q, q_q} << 1;
        diff = {1'b0, sh[2*WIDTH-1:WIDTH]} - {1'b0, dvs_q};
        r_nx = diff[WIDTH] ? sh[2*WIDTH-1:WIDTH] : diff[WIDTH-1:0];
        q_nx = {sh[WIDTH-1:1], ~diff[WIDTH]};
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dvs_d = bus.divisor;
                    dbz_d = 1'b0;
                    if (bus.divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        r_d     = '0;
                        q_d     = bus.dividend;
                        cnt_d   = CW'(WIDTH);
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                r_d   = r_nx;
                q_d   = q_nx;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    quo_d   = q_nx;
                    rem_d   = r_nx;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_4bit.sv
// Directed and table-driven checks for seq_divider_4bit.
// Inputs driven and outputs sampled on the falling edge.
module tb_seq_divider_4bit;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    seq_divider_4bit_if #(.WIDTH(4)) bus ();

    seq_divider_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // mode: 0 plain, 1 keep start high with junk, 2 scramble operands
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er,
                          input logic edbz, input int elat,
                          input int mode, input string name);
        int guard;
        int lat;
        int ndone;
        guard = 0;
        while (bus.busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        if (mode != 1) bus.start = 1'b0;
        lat   = 1;
        ndone = 0;
        while (!bus.done && lat < 20) begin
            chk({name, "_busy"}, bus.busy, 1'b1);
            if (mode != 0) begin
                bus.dividend = 4'($urandom);
                bus.divisor  = 4'($urandom_range(1, 15));
            end
            @(negedge clk);
            lat++;
        end
        if (bus.done) ndone++;
        bus.start = 1'b0;
        chk({name, "_lat"}, lat, elat);
        chk({name, "_q"}, bus.quotient, eq);
        chk({name, "_r"}, bus.remainder, er);
        chk({name, "_dbz"}, bus.div_by_zero, edbz);
        @(negedge clk);
        if (bus.done) ndone++;
        chk({name, "_ndone"}, ndone, 1);
        chk({name, "_idle"}, bus.busy, 1'b0);
    endtask

    vec_t vecs [9];

    initial begin
        total        = 0;
        bad          = 0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst_n        = 1'b0;

        vecs[0] = '{4'd13, 4'd4,  4'd3,  4'd1,  1'b0, 5};
        vecs[1] = '{4'd8,  4'd0,  4'hF,  4'd8,  1'b1, 1};
        vecs[2] = '{4'd6,  4'd3,  4'd2,  4'd0,  1'b0, 5};
        vecs[3] = '{4'd0,  4'd7,  4'd0,  4'd0,  1'b0, 5};
        vecs[4] = '{4'd9,  4'd1,  4'd9,  4'd0,  1'b0, 5};
        vecs[5] = '{4'd3,  4'd11, 4'd0,  4'd3,  1'b0, 5};
        vecs[6] = '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0, 5};
        vecs[7] = '{4'd14, 4'd9,  4'd1,  4'd5,  1'b0, 5};
        vecs[8] = '{4'd0,  4'd0,  4'hF,  4'd0,  1'b1, 1};

        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_q", bus.quotient, 4'd0);
        chk("rst_r", bus.remainder, 4'd0);
        chk("rst_dbz", bus.div_by_zero, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                   vecs[i].dbz, vecs[i].lat, 0, $sformatf("vec%0d", i));
        end

        // start held high during busy must not queue
        run_op(4'd10, 4'd5, 4'd2, 4'd0, 1'b0, 5, 1, "noqueue");
        @(negedge clk);
        chk("noqueue_after", bus.busy, 1'b0);

        // reset mid-run aborts with no done pulse
        run_op(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 5, 0, "pre_abort");
        bus.start    = 1'b1;
        bus.dividend = 4'd12;
        bus.divisor  = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_q", bus.quotient, 4'd0);
        chk("abort_r", bus.remainder, 4'd0);
        chk("abort_dbz", bus.div_by_zero, 1'b0);
        begin
            int nd;
            nd = 0;
            @(negedge clk);
            rst_n = 1'b1;
            repeat (6) begin
                @(negedge clk);
                if (bus.done) nd++;
            end
            chk("abort_nodone", nd, 0);
        end
        run_op(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 5, 0, "post_abort");

        // operands changing in flight must not matter
        run_op(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 5, 2, "capture");

        // dbz clears on the next accepted start
        run_op(4'd5, 4'd0, 4'hF, 4'd5, 1'b1, 1, 0, "dbz_set");
        run_op(4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 5, 0, "dbz_clr");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [3:0] eq;
                logic [3:0] er;
                if (b == 0) begin
                    eq = 4'hF;
                    er = 4'(a);
                end else begin
                    eq = 4'(a / b);
                    er = 4'(a % b);
                end
                run_op(4'(a), 4'(b), eq, er, (b == 0), (b == 0) ? 1 : 5,
                       0, $sformatf("sw_%0d_%0d", a, b));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
